// File: rtl/altro_rdo_seq.sv
// altro_rdo_seq
// Per-event channel readout sequencer for the ALTRO event builder (rdoclk domain).
// On a trigger it walks the channel enable mask. For each enabled channel it
// clears the builder RAM write address, waits out FIFO/builder backpressure,
// issues a CHRDO request and follows the ALTRO transfer strobe. Silent channels
// are skipped after a timeout. altro_chrdo_en frames the whole event; its
// falling edge lets the builder append the end-of-event marker.
module altro_rdo_seq #(
   parameter int NCH     = 128,
   parameter int TMO_CYC = 256,
   parameter int GAP_CYC = 24
) (
   input  logic           rdoclk,
   input  logic           reset,
   input  logic           trig,
   input  logic           abort,
   input  logic [NCH-1:0] ch_en,
   input  logic           trsfn,
   input  logic           fifo_almost_full,
   input  logic           fb_busy,
   output logic           chrdo_req,
   output logic [6:0]     chrdo_addr,
   output logic           altro_chrdo_en,
   output logic           ram_addrclr,
   output logic           seq_busy,
   output logic           evt_done,
   output logic [7:0]     tmo_cnt
);

   localparam logic [3:0] ST_IDLE   = 4'd0;
   localparam logic [3:0] ST_SCAN   = 4'd1;
   localparam logic [3:0] ST_CLR    = 4'd2;
   localparam logic [3:0] ST_WAITSP = 4'd3;
   localparam logic [3:0] ST_CMD    = 4'd4;
   localparam logic [3:0] ST_WAITT  = 4'd5;
   localparam logic [3:0] ST_XFER   = 4'd6;
   localparam logic [3:0] ST_GAP    = 4'd7;
   localparam logic [3:0] ST_END1   = 4'd8;
   localparam logic [3:0] ST_END2   = 4'd9;

   // The scan index stops at NCH (one past the last channel), so it needs 8 bits
   // even though channel addresses are only 7 bits wide.
   localparam logic [7:0]  IDX_STOP = 8'(NCH);
   localparam logic [15:0] TMO_LAST = 16'(TMO_CYC - 1);
   localparam logic [15:0] GAP_LAST = 16'(GAP_CYC - 1);

   logic [3:0]   state;
   logic [3:0]   state_nxt;
   logic [7:0]   idx;
   logic [7:0]   idx_nxt;
   logic [15:0]  timer;
   logic [15:0]  timer_nxt;
   logic [7:0]   tmo_nxt;
   logic [127:0] ch_en_ext;
   logic         trsf_sync1;
   logic         trsf_sync2;
   logic         trsf_s;
   logic         evt_active_nxt;

   // The mask is widened to the full 7-bit address space so any scan index can
   // select a bit without an out-of-range part select for small NCH.
   assign ch_en_ext = 128'(ch_en);

   // Two-flop synchroniser for the asynchronous, active-low transfer strobe.
   // The flops reset to 1 so that no transfer is seen while in reset.
   always_ff @(posedge rdoclk or posedge reset) begin
      if (reset) begin
         trsf_sync1 <= 1'b1;
         trsf_sync2 <= 1'b1;
      end else begin
         trsf_sync1 <= trsfn;
         trsf_sync2 <= trsf_sync1;
      end
   end

   assign trsf_s = ~trsf_sync2;

   // Next-state logic. Abort preempts every active state except the END
   // cycles. It leaves the index and the timeout count untouched.
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      timer_nxt = timer;
      tmo_nxt   = tmo_cnt;
      if (abort && (state != ST_IDLE) && (state != ST_END1) && (state != ST_END2)) begin
         state_nxt = ST_END1;
      end else begin
         case (state)
            ST_IDLE: begin
               if (trig) begin
                  state_nxt = ST_SCAN;
                  idx_nxt   = 8'd0;
                  tmo_nxt   = 8'd0;
               end
            end
            ST_SCAN: begin
               if (idx == IDX_STOP) begin
                  state_nxt = ST_END1;
               end else if (ch_en_ext[idx[6:0]]) begin
                  state_nxt = ST_CLR;
               end else begin
                  idx_nxt = idx + 8'd1;
               end
            end
            ST_CLR: begin
               state_nxt = ST_WAITSP;
            end
            ST_WAITSP: begin
               if (!fifo_almost_full && !fb_busy) begin
                  state_nxt = ST_CMD;
               end
            end
            ST_CMD: begin
               timer_nxt = 16'd0;
               state_nxt = ST_WAITT;
            end
            ST_WAITT: begin
               if (trsf_s) begin
                  state_nxt = ST_XFER;
               end else if (timer == TMO_LAST) begin
                  tmo_nxt   = (tmo_cnt == 8'hFF) ? tmo_cnt : tmo_cnt + 8'd1;
                  idx_nxt   = idx + 8'd1;
                  state_nxt = ST_SCAN;
               end else begin
                  timer_nxt = timer + 16'd1;
               end
            end
            ST_XFER: begin
               if (!trsf_s) begin
                  timer_nxt = 16'd0;
                  state_nxt = ST_GAP;
               end
            end
            ST_GAP: begin
               if (timer == GAP_LAST) begin
                  if (!fb_busy) begin
                     idx_nxt   = idx + 8'd1;
                     state_nxt = ST_SCAN;
                  end
               end else begin
                  timer_nxt = timer + 16'd1;
               end
            end
            ST_END1: begin
               state_nxt = ST_END2;
            end
            ST_END2: begin
               state_nxt = ST_IDLE;
            end
            default: begin
               state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   // The event window is high in every state between IDLE and END.
   assign evt_active_nxt = (state_nxt != ST_IDLE) && (state_nxt != ST_END1) &&
                           (state_nxt != ST_END2);

   // State registers. The channel address is loaded on entry to CMD so that it is
   // valid during the request pulse and is held until the next request.
   always_ff @(posedge rdoclk or posedge reset) begin
      if (reset) begin
         state          <= ST_IDLE;
         idx            <= 8'd0;
         timer          <= 16'd0;
         tmo_cnt        <= 8'd0;
         chrdo_addr     <= 7'd0;
         altro_chrdo_en <= 1'b0;
      end else begin
         state          <= state_nxt;
         idx            <= idx_nxt;
         timer          <= timer_nxt;
         tmo_cnt        <= tmo_nxt;
         altro_chrdo_en <= evt_active_nxt;
         if (state_nxt == ST_CMD) begin
            chrdo_addr <= idx[6:0];
         end
      end
   end

   assign chrdo_req   = (state == ST_CMD);
   assign ram_addrclr = (state == ST_CLR);
   assign seq_busy    = (state != ST_IDLE);
   assign evt_done    = (state == ST_END1);

endmodule

// File: tb/tb_altro_rdo_seq.sv
// tb_altro_rdo_seq
// Scoreboard bench for the ALTRO readout sequencer. Each event pushes the
// channel addresses that must be requested, in ascending order. It also pushes
// the timeout count expected at evt_done. A negedge monitor pops these queues
// whenever the DUT pulses chrdo_req or evt_done. A behavioural ALTRO model
// answers requests for the channels marked responsive.
module tb_altro_rdo_seq;

   localparam int NCH     = 8;
   localparam int TMO_CYC = 16;
   localparam int GAP_CYC = 24;

   logic           rdoclk = 1'b0;
   logic           reset;
   logic           trig;
   logic           abort;
   logic [NCH-1:0] ch_en;
   logic           trsfn;
   logic           fifo_almost_full;
   logic           fb_busy;
   logic           chrdo_req;
   logic [6:0]     chrdo_addr;
   logic           altro_chrdo_en;
   logic           ram_addrclr;
   logic           seq_busy;
   logic           evt_done;
   logic [7:0]     tmo_cnt;

   logic dir_faf, dir_busy, noise_on, noise_faf, noise_busy;

   int exp_req_q[$];
   int exp_done_q[$];
   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int req_count = 0, clr_count = 0, done_count = 0, rel_count = 0;
   int last_req_cyc, last_clr_cyc, last_done_cyc, rel_cyc;
   int en_rise_cyc, en_run = 0, en_last_run = 0;
   int clr_pending = 0;
   bit gap_armed = 0;
   bit prev_done = 0;
   bit respond[128];
   bit resp_busy = 0;
   bit long_xfer = 0;

   assign fifo_almost_full = dir_faf | (noise_on & noise_faf);
   assign fb_busy          = dir_busy | (noise_on & noise_busy);

   altro_rdo_seq #(.NCH(NCH), .TMO_CYC(TMO_CYC), .GAP_CYC(GAP_CYC)) dut (
      .rdoclk           (rdoclk),
      .reset            (reset),
      .trig             (trig),
      .abort            (abort),
      .ch_en            (ch_en),
      .trsfn            (trsfn),
      .fifo_almost_full (fifo_almost_full),
      .fb_busy          (fb_busy),
      .chrdo_req        (chrdo_req),
      .chrdo_addr       (chrdo_addr),
      .altro_chrdo_en   (altro_chrdo_en),
      .ram_addrclr      (ram_addrclr),
      .seq_busy         (seq_busy),
      .evt_done         (evt_done),
      .tmo_cnt          (tmo_cnt)
   );

   // 100 MHz readout clock
   always #5 rdoclk = ~rdoclk;

   // Cycle number of the current clock period, used for all timing measurements
   always @(posedge rdoclk) cyc <= cyc + 1;

   function automatic void checkOutput(input string name, input longint actual, input longint expected);
      n_checks++;
      if (actual == expected) n_pass++;
      else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
   endfunction

   function automatic void checkMin(input string name, input longint actual, input longint minimum);
      n_checks++;
      if (actual >= minimum) n_pass++;
      else $display("[TB] FAIL %s: got %0d, required at least %0d", name, actual, minimum);
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge rdoclk);
      #1;
   endtask

   function automatic int counterOf(input int which);
      case (which)
         0: return req_count;
         1: return clr_count;
         2: return done_count;
         default: return rel_count;
      endcase
   endfunction

   // Bounded wait for one of the monitor counters to reach a target
   task automatic waitUntil(input string name, input int which, input int target, input int budget);
      int n = 0;
      while (counterOf(which) < target && n < budget) begin
         tick(1);
         n++;
      end
      if (counterOf(which) < target) checkOutput({name, "_timeout"}, counterOf(which), target);
   endtask

   task automatic waitRespIdle();
      int n = 0;
      while (resp_busy && n < 200) begin
         tick(1);
         n++;
      end
      if (resp_busy) checkOutput("resp_idle_timeout", resp_busy, 0);
   endtask

   // Reference model: every enabled channel is requested once in ascending
   // order; each silent one adds a timeout (saturating at 255).
   task automatic applyStimulus(input logic [NCH-1:0] mask, input logic [NCH-1:0] resp, output int trig_cyc);
      int tmo = 0;
      ch_en = mask;
      for (int i = 0; i < NCH; i++) begin
         respond[i] = resp[i];
         if (mask[i]) begin
            exp_req_q.push_back(i);
            if (!resp[i]) tmo++;
         end
      end
      exp_done_q.push_back(tmo > 255 ? 255 : tmo);
      clr_pending = 0;
      gap_armed   = 0;
      trig        = 1'b1;
      trig_cyc    = cyc;
      tick(1);
      trig = 1'b0;
   endtask

   task automatic finishEvent(input int done_target);
      waitUntil("evt_done", 2, done_target, 3000);
      checkOutput("leftover_reqs", exp_req_q.size(), 0);
      waitRespIdle();
      tick(3);
   endtask

   // ALTRO model: answers a request after a short delay with a low trsfn burst
   initial begin
      int dly, rlen;
      trsfn = 1'b1;
      forever begin
         @(negedge rdoclk);
         if (chrdo_req === 1'b1 && respond[chrdo_addr]) begin
            resp_busy = 1;
            dly  = long_xfer ? 2 : $urandom_range(2, 8);
            rlen = long_xfer ? 30 : $urandom_range(3, 12);
            repeat (dly) @(posedge rdoclk);
            #1 trsfn = 1'b0;
            repeat (rlen) @(posedge rdoclk);
            #1 trsfn = 1'b1;
            rel_cyc   = cyc;
            gap_armed = seq_busy;
            rel_count++;
            resp_busy = 0;
         end
      end
   end

   // Random backpressure generator, active only during the randomized events
   initial begin
      noise_faf  = 1'b0;
      noise_busy = 1'b0;
      forever begin
         @(posedge rdoclk);
         #1;
         noise_faf  = ($urandom_range(0, 3) == 0);
         noise_busy = ($urandom_range(0, 3) == 0);
      end
   end

   // Monitor: pops the scoreboard on request/done pulses and tracks event timing
   always @(negedge rdoclk) begin
      if (!reset) begin
         if (altro_chrdo_en) begin
            if (en_run == 0) en_rise_cyc = cyc;
            en_run++;
         end else begin
            if (en_run != 0) en_last_run = en_run;
            en_run = 0;
         end
         if (prev_done) begin
            checkOutput("en_low_end2", altro_chrdo_en, 0);
            checkOutput("done_single", evt_done, 0);
            prev_done = 0;
         end
         if (ram_addrclr) begin
            clr_count++;
            last_clr_cyc = cyc;
            clr_pending++;
            if (gap_armed) begin
               checkMin("gap_len", cyc - rel_cyc, GAP_CYC + 4);
               gap_armed = 0;
            end
         end
         if (chrdo_req) begin
            int e;
            e = (exp_req_q.size() > 0) ? exp_req_q.pop_front() : -1;
            checkOutput("req_addr", chrdo_addr, e);
            checkOutput("clr_before_req", clr_pending, 1);
            clr_pending  = 0;
            req_count++;
            last_req_cyc = cyc;
         end
         if (evt_done) begin
            int e;
            e = (exp_done_q.size() > 0) ? exp_done_q.pop_front() : -1;
            checkOutput("done_tmo", tmo_cnt, e);
            checkOutput("done_en_low", altro_chrdo_en, 0);
            done_count++;
            last_done_cyc = cyc;
            gap_armed     = 0;
            prev_done     = 1;
         end
      end
   end

   initial begin
      #600000;
      $display("[TB] FAIL watchdog: simulation did not finish, %0d of %0d passed", n_pass, n_checks);
      $fatal(1, "[TB] watchdog");
   end

   // Directed scenarios followed by randomized events
   initial begin
      int t, r, b, ab, fall, rb, cb;
      logic [31:0] rnd;
      reset = 1'b1; trig = 1'b0; abort = 1'b0; ch_en = '0;
      dir_faf = 1'b0; dir_busy = 1'b0; noise_on = 1'b0;
      for (int i = 0; i < 128; i++) respond[i] = 0;
      tick(3);
      checkOutput("rst_seq_busy", seq_busy, 0);
      checkOutput("rst_en", altro_chrdo_en, 0);
      checkOutput("rst_req", chrdo_req, 0);
      checkOutput("rst_clr", ram_addrclr, 0);
      checkOutput("rst_done", evt_done, 0);
      checkOutput("rst_tmo", tmo_cnt, 0);
      reset = 1'b0;
      tick(2);

      // Two enabled channels, both answering
      $display("[TB] two-channel event");
      applyStimulus(8'b0000_0101, 8'b0000_0101, t);
      waitUntil("clr1", 1, clr_count + 1, 50);
      checkOutput("first_clr_cyc", last_clr_cyc - t, 2);
      waitUntil("req1", 0, 1, 50);
      checkOutput("first_req_cyc", last_req_cyc - t, 4);
      finishEvent(1);
      checkOutput("en_rise", en_rise_cyc - t, 1);
      checkOutput("en_len", en_last_run, last_done_cyc - t - 1);
      checkOutput("req_total", req_count, 2);

      // Empty mask: pure scan
      $display("[TB] empty mask");
      rb = req_count; cb = clr_count;
      applyStimulus(8'h00, 8'h00, t);
      finishEvent(2);
      checkOutput("empty_done_cyc", last_done_cyc - t, NCH + 2);
      checkOutput("empty_en_len", en_last_run, NCH + 1);
      checkOutput("empty_reqs", req_count, rb);
      checkOutput("empty_clrs", clr_count, cb);

      // Silent channel times out
      $display("[TB] timeout");
      applyStimulus(8'h02, 8'h00, t);
      waitUntil("tmo_req", 0, rb + 1, 50);
      r = last_req_cyc;
      finishEvent(3);
      checkOutput("tmo_done_delay", last_done_cyc - r, TMO_CYC + NCH);

      // FIFO almost full for 50 cycles, then builder busy stretches the gap
      $display("[TB] backpressure");
      rb = req_count; cb = clr_count;
      dir_faf = 1'b1;
      applyStimulus(8'b0000_0101, 8'b0000_0101, t);
      waitUntil("bp_clr", 1, cb + 1, 50);
      checkOutput("bp_clr_cyc", last_clr_cyc - t, 2);
      tick(t + 50 - cyc);
      dir_faf = 1'b0;
      fall = cyc;
      waitUntil("bp_req", 0, rb + 1, 50);
      checkOutput("bp_req_cyc", last_req_cyc - fall, 1);
      waitUntil("bp_rel", 3, rel_count + 1, 60);
      dir_busy = 1'b1;
      tick(40);
      dir_busy = 1'b0;
      b = cyc;
      waitUntil("bp_clr2", 1, cb + 2, 50);
      checkOutput("bp_clr2_cyc", last_clr_cyc - b, 3);
      checkMin("bp_gap_stretched", last_clr_cyc - rel_cyc, 40);
      finishEvent(4);

      // Abort while waiting for channel 3's transfer
      $display("[TB] abort");
      rb = req_count;
      applyStimulus(8'hFF, 8'hF7, t);
      waitUntil("ab_req3", 0, rb + 4, 1000);
      tick(3);
      exp_req_q.delete();
      exp_done_q.delete();
      exp_done_q.push_back(0);
      abort = 1'b1;
      ab = cyc;
      tick(1);
      abort = 1'b0;
      finishEvent(5);
      checkOutput("ab_done_cyc", last_done_cyc - ab, 1);
      checkOutput("ab_req_count", req_count, rb + 4);
      checkOutput("ab_en_len", en_last_run, ab - t);

      // Reset in the middle of a transfer
      $display("[TB] reset mid-transfer");
      long_xfer = 1;
      rb = req_count;
      applyStimulus(8'h01, 8'h01, t);
      waitUntil("rs_req", 0, rb + 1, 50);
      tick(8);
      reset = 1'b1;
      #1;
      checkOutput("mid_rst_busy", seq_busy, 0);
      checkOutput("mid_rst_en", altro_chrdo_en, 0);
      checkOutput("mid_rst_req", chrdo_req, 0);
      checkOutput("mid_rst_clr", ram_addrclr, 0);
      checkOutput("mid_rst_done", evt_done, 0);
      checkOutput("mid_rst_tmo", tmo_cnt, 0);
      checkOutput("mid_rst_addr", chrdo_addr, 0);
      exp_req_q.delete();
      exp_done_q.delete();
      clr_pending = 0;
      gap_armed   = 0;
      tick(2);
      reset = 1'b0;
      waitRespIdle();
      long_xfer = 0;
      tick(3);
      rb = req_count;
      applyStimulus(8'h01, 8'h01, t);
      waitUntil("post_rst_req", 0, rb + 1, 50);
      checkOutput("post_rst_req_cyc", last_req_cyc - t, 4);
      finishEvent(6);

      // Randomized masks, responsiveness and backpressure
      $display("[TB] random events");
      noise_on = 1'b1;
      for (int k = 0; k < 20; k++) begin
         logic [NCH-1:0] m, rs;
         rnd = $urandom; m  = rnd[NCH-1:0];
         rnd = $urandom; rs = rnd[NCH-1:0];
         applyStimulus(m, rs, t);
         finishEvent(7 + k);
      end
      noise_on = 1'b0;
      tick(5);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
